// File: rtl/pixel_stage_pkg.sv
// Shared encodings for the pixel transform stage: transform modes, read-issue
// FSM states and the fixed-point luma coefficients.
package pixel_stage_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_GRAY = 2'd1,
    MODE_INV  = 2'd2,
    MODE_THR  = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } rd_state_e;

  // Y = (77*R + 150*G + 29*B) >> 8
  localparam int unsigned GRAY_CR    = 77;
  localparam int unsigned GRAY_CG    = 150;
  localparam int unsigned GRAY_CB    = 29;
  localparam int unsigned GRAY_SHIFT = 8;

endpackage

// File: rtl/pixel_sync_fifo.sv
// Parametrised synchronous FIFO, registered read data (no fall-through),
// synchronous flush, occupancy and almost-empty status.
module pixel_sync_fifo #(
  parameter int DW     = 12,
  parameter int AW     = 10,
  parameter int AE_LVL = 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          i_flush,
  input  logic          i_wr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_rd,
  output logic [DW-1:0] o_rdata,
  output logic [AW:0]   o_fill,
  output logic          o_almostempty,
  output logic          o_empty
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_fill;
  logic [DW-1:0] r_rdata;
  logic          w_full, w_do_wr, w_do_rd;

  assign o_empty       = (r_fill == '0);
  assign w_full        = (r_fill == (AW+1)'(DEPTH));
  assign w_do_wr       = i_wr && !i_flush;
  assign w_do_rd       = i_rd && !o_empty && !i_flush;
  assign o_fill        = r_fill;
  assign o_almostempty = (r_fill <= (AW+1)'(AE_LVL));
  assign o_rdata       = r_rdata;

  always_ff @(posedge CLK) begin
    if (w_do_wr) r_mem[r_wp] <= i_wdata;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_fill  <= '0;
      r_rdata <= '0;
    end else if (i_flush) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_fill <= '0;
    end else begin
      if (w_do_wr) r_wp <= r_wp + 1'b1;
      if (w_do_rd) begin
        r_rp    <= r_rp + 1'b1;
        r_rdata <= r_mem[r_rp];
      end
      case ({w_do_wr, w_do_rd})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
    end
  end

  // Upstream credit accounting must make a write into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge CLK) disable iff (!RST) !(w_do_wr && w_full));

endmodule

// File: rtl/pixel_xform.sv
// Pixel pipeline: tags the issue cycle, captures upstream data into s0 and
// produces the s1 transform result that is written straight into the output FIFO.
module pixel_xform
  import pixel_stage_pkg::*;
#(
  parameter int CH_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              i_flush,
  input  logic              i_iss_vld,
  input  mode_e             i_iss_mode,
  input  logic [3*CH_W-1:0] i_data,
  input  logic [CH_W-1:0]   i_thresh,
  output logic              o_wr_en,
  output logic [3*CH_W-1:0] o_wr_data
);

  localparam int PIX_W = 3 * CH_W;
  localparam int LW    = CH_W + 8;

  logic             r_tag_vld;
  mode_e            r_tag_mode;
  logic             r_s0_vld;
  mode_e            r_s0_mode;
  logic [PIX_W-1:0] r_s0_pix;

  logic [CH_W-1:0]  w_r, w_g, w_b, w_y;
  logic [LW-1:0]    w_luma;
  logic [PIX_W-1:0] w_xf;

  // The tag covers the cycle in which upstream drives i_data for that issue.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_tag_vld  <= 1'b0;
      r_tag_mode <= MODE_PASS;
      r_s0_vld   <= 1'b0;
      r_s0_mode  <= MODE_PASS;
      r_s0_pix   <= '0;
    end else begin
      r_tag_vld  <= i_iss_vld && !i_flush;
      r_tag_mode <= i_iss_mode;
      r_s0_vld   <= r_tag_vld && !i_flush;
      r_s0_mode  <= r_tag_mode;
      r_s0_pix   <= i_data;
    end
  end

  assign {w_r, w_g, w_b} = r_s0_pix;
  assign w_luma = LW'(GRAY_CR) * LW'(w_r)
                + LW'(GRAY_CG) * LW'(w_g)
                + LW'(GRAY_CB) * LW'(w_b);
  assign w_y = CH_W'(w_luma >> GRAY_SHIFT);

  always_comb begin
    w_xf = r_s0_pix;
    case (r_s0_mode)
      MODE_PASS: w_xf = r_s0_pix;
      MODE_GRAY: w_xf = {3{w_y}};
      MODE_INV:  w_xf = ~r_s0_pix;
      MODE_THR:  w_xf = (w_y >= i_thresh) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
    endcase
  end

  assign o_wr_en   = r_s0_vld && !i_flush;
  assign o_wr_data = w_xf;

endmodule

// File: rtl/pixel_xform_stage.sv
// Credit-gated pixel transform stage between an upstream pixel FIFO and the
// edge kernels. Optional stats counters under `PIXEL_STAGE_STATS_EN.
module pixel_xform_stage
  import pixel_stage_pkg::*;
#(
  parameter int CH_W    = 4,
  parameter int FIFO_AW = 10,
  parameter int AE_LVL  = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              i_flush,
  input  logic [1:0]        i_mode,
  input  logic [CH_W-1:0]   i_thresh,
  input  logic [3*CH_W-1:0] i_data,
  input  logic              i_almostempty,
  output logic              o_rd,
  input  logic              i_rd,
  output logic [3*CH_W-1:0] o_data,
  output logic [FIFO_AW:0]  o_fill,
  output logic              o_almostempty,
`ifdef PIXEL_STAGE_STATS_EN
  output logic [31:0]       o_pix_cnt,
  output logic [31:0]       o_stall_cnt,
`endif
  output logic              o_empty
);

  localparam int PIX_W = 3 * CH_W;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = FIFO_AW + 2;

  rd_state_e        r_state, w_state_nxt;
  mode_e            r_iss_mode;
  logic [1:0]       r_inflight;
  logic [CW-1:0]    w_committed;
  logic             w_credit_ok, w_issue_ok;
  logic             w_wr_en;
  logic [PIX_W-1:0] w_wr_data;

  // Every issued pixel already owns a FIFO slot until it is written.
  assign w_committed = {1'b0, o_fill} + CW'(r_inflight) + CW'(1);
  assign w_credit_ok = (w_committed <= CW'(DEPTH));
  assign w_issue_ok  = !i_almostempty && !i_flush && w_credit_ok;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_issue_ok)  w_state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (!w_issue_ok) w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_rd = (r_state == ST_ACTIVE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_iss_mode <= MODE_PASS;
      r_inflight <= '0;
    end else begin
      if (w_issue_ok) r_iss_mode <= mode_e'(i_mode);
      if (i_flush) begin
        r_inflight <= '0;
      end else begin
        case ({w_issue_ok, w_wr_en})
          2'b10:   r_inflight <= r_inflight + 1'b1;
          2'b01:   r_inflight <= r_inflight - 1'b1;
          default: r_inflight <= r_inflight;
        endcase
      end
    end
  end

  pixel_xform #(
    .CH_W (CH_W)
  ) u_xform (
    .CLK        (CLK),
    .RST        (RST),
    .i_flush    (i_flush),
    .i_iss_vld  (o_rd),
    .i_iss_mode (r_iss_mode),
    .i_data     (i_data),
    .i_thresh   (i_thresh),
    .o_wr_en    (w_wr_en),
    .o_wr_data  (w_wr_data)
  );

  pixel_sync_fifo #(
    .DW     (PIX_W),
    .AW     (FIFO_AW),
    .AE_LVL (AE_LVL)
  ) u_fifo (
    .CLK           (CLK),
    .RST           (RST),
    .i_flush       (i_flush),
    .i_wr          (w_wr_en),
    .i_wdata       (w_wr_data),
    .i_rd          (i_rd),
    .o_rdata       (o_data),
    .o_fill        (o_fill),
    .o_almostempty (o_almostempty),
    .o_empty       (o_empty)
  );

`ifdef PIXEL_STAGE_STATS_EN
  logic [31:0] r_pix_cnt, r_stall_cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_pix_cnt   <= '0;
      r_stall_cnt <= '0;
    end else if (i_flush) begin
      r_pix_cnt   <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_wr_en) r_pix_cnt <= r_pix_cnt + 32'd1;
      if (!i_almostempty && !w_credit_ok) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign o_pix_cnt   = r_pix_cnt;
  assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pixel_xform_stage.sv
// Directed bench for pixel_xform_stage with an 8-deep output FIFO and a
// behavioural upstream FIFO that answers o_rd one cycle later.
module tb_pixel_xform_stage;

  localparam int CH_W    = 4;
  localparam int FIFO_AW = 3;
  localparam int AE_LVL  = 1;
  localparam int PIX_W   = 3 * CH_W;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             i_flush = 1'b0;
  logic [1:0]       i_mode = 2'd0;
  logic [CH_W-1:0]  i_thresh = '0;
  logic [PIX_W-1:0] i_data;
  logic             i_almostempty = 1'b1;
  logic             o_rd;
  logic             i_rd = 1'b0;
  logic [PIX_W-1:0] o_data;
  logic [FIFO_AW:0] o_fill;
  logic             o_almostempty;
  logic             o_empty;
`ifdef PIXEL_STAGE_STATS_EN
  logic [31:0]      pix_cnt, stall_cnt;
`endif

  pixel_xform_stage #(
    .CH_W    (CH_W),
    .FIFO_AW (FIFO_AW),
    .AE_LVL  (AE_LVL)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .i_flush       (i_flush),
    .i_mode        (i_mode),
    .i_thresh      (i_thresh),
    .i_data        (i_data),
    .i_almostempty (i_almostempty),
    .o_rd          (o_rd),
    .i_rd          (i_rd),
    .o_data        (o_data),
    .o_fill        (o_fill),
    .o_almostempty (o_almostempty),
`ifdef PIXEL_STAGE_STATS_EN
    .o_pix_cnt     (pix_cnt),
    .o_stall_cnt   (stall_cnt),
`endif
    .o_empty       (o_empty)
  );

  always #5 CLK = ~CLK;

  int         n_chk = 0;
  int         n_err = 0;
  int         up_pops = 0;
  int         max_fill = 0;
  logic [11:0] up_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Upstream FIFO: a strobe seen in one cycle yields data the next cycle.
  initial begin
    logic seen;
    i_data = '0;
    forever begin
      @(negedge CLK);
      seen = o_rd;
      @(posedge CLK);
      #1;
      if (seen) begin
        up_pops++;
        if (up_q.size() > 0) i_data = up_q.pop_front();
        else                 i_data = '0;
      end
    end
  end

  always @(negedge CLK) begin
    if (int'(o_fill) > max_fill) max_fill = int'(o_fill);
  end

  task automatic issue(input int n);
    i_almostempty = 1'b0;
    repeat (n) @(negedge CLK);
    i_almostempty = 1'b1;
  endtask

  task automatic rd_expect(input string tag, input logic [11:0] exp);
    i_rd = 1'b1;
    @(negedge CLK);
    i_rd = 1'b0;
    chk(tag, 32'(o_data), 32'(exp));
  endtask

  initial begin
    int pops0;
    logic [11:0] bp_val;

    repeat (2) @(negedge CLK);
    chk("rst_rd",    32'(o_rd), 0);
    chk("rst_fill",  32'(o_fill), 0);
    chk("rst_empty", 32'(o_empty), 1);
    chk("rst_ae",    32'(o_almostempty), 1);
    RST = 1'b1;
    @(negedge CLK);

    // Gray, including first-write latency
    up_q = '{12'hF00, 12'hFFF, 12'h000};
    i_mode = 2'd1;
    i_almostempty = 1'b0;
    @(negedge CLK);
    chk("gray_rd_issue", 32'(o_rd), 1);
    chk("gray_fill_t0", 32'(o_fill), 0);
    @(negedge CLK);
    @(negedge CLK);
    i_almostempty = 1'b1;
    chk("gray_fill_t2", 32'(o_fill), 0);
    @(negedge CLK);
    chk("gray_fill_t3", 32'(o_fill), 1);
    repeat (3) @(negedge CLK);
    chk("gray_fill", 32'(o_fill), 3);
    chk("gray_ae", 32'(o_almostempty), 0);
    rd_expect("gray_0", 12'h444);
    rd_expect("gray_1", 12'hFFF);
    rd_expect("gray_2", 12'h000);
    chk("gray_empty", 32'(o_empty), 1);

    // Invert then pass
    up_q = '{12'h123, 12'hA5C};
    i_mode = 2'd2;
    issue(1);
    i_mode = 2'd0;
    issue(1);
    repeat (4) @(negedge CLK);
    chk("invpass_fill", 32'(o_fill), 2);
    rd_expect("inv_0",  12'hEDC);
    rd_expect("pass_0", 12'hA5C);

    // Threshold at the >= boundary
    up_q = '{12'h888, 12'h777};
    i_thresh = 4'd8;
    i_mode = 2'd3;
    issue(2);
    repeat (4) @(negedge CLK);
    rd_expect("thr_hi", 12'hFFF);
    rd_expect("thr_lo", 12'h000);

    // Mode switch on the cycle after an issue
    up_q = '{12'hF00, 12'h123};
    i_mode = 2'd1;
    i_almostempty = 1'b0;
    @(negedge CLK);
    i_mode = 2'd2;
    @(negedge CLK);
    i_almostempty = 1'b1;
    repeat (4) @(negedge CLK);
    rd_expect("msw_gray", 12'h444);
    rd_expect("msw_inv",  12'hEDC);

    // Backpressure with an always-ready upstream
    up_q.delete();
    for (int i = 0; i < 12; i++) up_q.push_back(12'h0A1 + 12'(i * 17));
    i_mode = 2'd0;
    pops0 = up_pops;
    i_almostempty = 1'b0;
    repeat (20) @(negedge CLK);
    chk("bp_fill", 32'(o_fill), 8);
    chk("bp_rd_stopped", 32'(o_rd), 0);
    chk("bp_pops", 32'(up_pops - pops0), 8);
    chk("bp_max_fill", 32'(max_fill), 8);
    chk("bp_not_empty", 32'(o_empty), 0);
    i_almostempty = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bp_val = 12'h0A1 + 12'(i * 17);
      rd_expect("bp_data", bp_val);
      if (i == 5) chk("bp_ae_fill2", 32'(o_almostempty), 0);
      if (i == 6) chk("bp_ae_fill1", 32'(o_almostempty), 1);
    end
    chk("bp_drained", 32'(o_empty), 1);
    i_rd = 1'b1;
    @(negedge CLK);
    i_rd = 1'b0;
    chk("empty_rd_data", 32'(o_data), 32'(12'h0A1 + 12'(7 * 17)));
    chk("empty_rd_fill", 32'(o_fill), 0);
    up_q.delete();

    // Flush with fill=5 and two pixels in flight
    for (int i = 0; i < 7; i++) up_q.push_back(12'h300 + 12'(i));
    issue(5);
    repeat (4) @(negedge CLK);
    chk("fl_pre_fill", 32'(o_fill), 5);
    i_almostempty = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    i_almostempty = 1'b1;
    i_flush = 1'b1;
    @(negedge CLK);
    i_flush = 1'b0;
    chk("fl_fill", 32'(o_fill), 0);
    chk("fl_empty", 32'(o_empty), 1);
    chk("fl_rd", 32'(o_rd), 0);
    repeat (6) @(negedge CLK);
    chk("fl_no_write", 32'(o_fill), 0);
    up_q = '{12'h3C5, 12'h5A3};
    issue(2);
    repeat (4) @(negedge CLK);
    chk("fl_resume_fill", 32'(o_fill), 2);
    rd_expect("fl_resume_0", 12'h3C5);
    rd_expect("fl_resume_1", 12'h5A3);

    // Asynchronous reset mid-stream
    up_q = '{12'h111, 12'h222, 12'h333, 12'h444};
    i_mode = 2'd2;
    i_almostempty = 1'b0;
    repeat (4) @(negedge CLK);
    #2;
    RST = 1'b0;
    i_almostempty = 1'b1;
    #1;
    chk("arst_rd", 32'(o_rd), 0);
    chk("arst_fill", 32'(o_fill), 0);
    chk("arst_empty", 32'(o_empty), 1);
    @(negedge CLK);
    RST = 1'b1;
    repeat (6) @(negedge CLK);
    chk("arst_no_write", 32'(o_fill), 0);
    up_q.delete();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
